// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and frame-size defaults for the conv frame sequencer
package conv_pkg;

    localparam int IMG_W_DEF     = 28;
    localparam int IMG_H_DEF     = 28;
    localparam int PIX_PER_FRAME = IMG_W_DEF * IMG_H_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// rtl/conv_frame_sequencer_if.sv - image RAM read port and conv stream bundle
interface conv_frame_sequencer_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = $clog2(PIX_PER_FRAME)
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              conv_valid;
    logic [7:0]        conv_data;
    logic              conv_ovalid;
    logic              ds_ready;

    modport master (
        output mem_rd_en, mem_addr, conv_valid, conv_data,
        input  mem_rdata, conv_ovalid, ds_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, conv_valid, conv_data,
        output mem_rdata, conv_ovalid, ds_ready
    );
endinterface

// File: rtl/seq_beat_counter.sv
// rtl/seq_beat_counter.sv - saturating up-counter with clear and terminal-count flag
module seq_beat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign at_max = (count == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - streams one frame from image RAM into the conv, flushes it, counts outputs
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int N_OUT     = (IMG_W - 1) * (IMG_H - 1),
    parameter int FLUSH_MAX = 2 * IMG_W + 8,
    parameter int ADDR_W    = $clog2(IMG_W * IMG_H)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    conv_frame_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int PIX   = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(PIX + 1);
    localparam int FL_W  = $clog2(FLUSH_MAX + 1);

    seq_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic              feed_d1;
    logic              valid_q;
    logic [7:0]        data_q;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [FL_W-1:0]   flush_cnt;
    logic              pix_full, out_tc, flush_tc;
    logic              start_acc, rd_en, last_rd, out_en, out_hit, flush_issue;

    assign start_acc   = (state == ST_IDLE) && start;
    assign rd_en       = (state == ST_FEED) && bus.ds_ready && !pix_full;
    assign last_rd     = rd_en && (pix_cnt == CNT_W'(PIX - 1));
    assign out_en      = bus.conv_ovalid && ((state == ST_FEED) || (state == ST_FLUSH));
    // Look one beat ahead so done lands the cycle after the final conv output.
    assign out_hit     = out_tc || (out_en && (out_cnt == CNT_W'(N_OUT - 1)));
    assign flush_issue = (state == ST_FLUSH) && bus.ds_ready && (flush_cnt < FL_W'(FLUSH_MAX));

    seq_beat_counter #(.W(CNT_W), .MAX(PIX)) u_pix_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(rd_en),
        .count(pix_cnt), .at_max(pix_full)
    );

    seq_beat_counter #(.W(CNT_W), .MAX(N_OUT)) u_out_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(out_en),
        .count(out_cnt), .at_max(out_tc)
    );

    seq_beat_counter #(.W(FL_W), .MAX(FLUSH_MAX)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(flush_issue),
        .count(flush_cnt), .at_max(flush_tc)
    );

    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_addr   = addr_q;
    assign bus.conv_valid = valid_q;
    // RAM data is forwarded in its valid cycle; otherwise the last driven value is held.
    assign bus.conv_data  = feed_d1 ? bus.mem_rdata : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            feed_d1 <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            feed_d1 <= rd_en;
            valid_q <= rd_en || flush_issue;
            done    <= 1'b0;
            if (flush_issue) begin
                data_q <= '0;
            end else if (feed_d1) begin
                data_q <= bus.mem_rdata;
            end
            if (rd_en) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state  <= ST_FEED;
                        busy   <= 1'b1;
                        error  <= 1'b0;
                        addr_q <= '0;
                    end
                end
                ST_FEED: begin
                    if (last_rd) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (out_hit) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (flush_tc) begin
                        state <= ST_ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: state <= ST_IDLE;
                default:         state <= ST_IDLE;
            endcase
        end
    end
endmodule
